// File: rtl/sv32_page_walker.sv
// Sv32 two-level page-table walker servicing TLB misses over a single-outstanding read port.
// Optional one-entry L1 pointer PTE cache: define SV32_PTW_PTE_CACHE_EN.
module sv32_page_walker #(
   parameter int PPN_WD   = 22,
   parameter int VPN1_WD  = 10,
   parameter int VPN0_WD  = 10,
   parameter int ASID_WD  = 9,
   parameter int PHY_ADDR = 34
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       req_valid_i,
   output logic                       req_ready_o,
   input  logic [VPN1_WD+VPN0_WD-1:0] req_vpn_i,
   input  logic [ASID_WD-1:0]         req_asid_i,
   input  logic [PPN_WD-1:0]          satp_ppn_i,
   input  logic                       flush_i,
   output logic                       mem_req_valid_o,
   input  logic                       mem_req_ready_i,
   output logic [PHY_ADDR-1:0]        mem_req_addr_o,
   input  logic                       mem_rsp_valid_i,
   input  logic [31:0]                mem_rsp_data_i,
   input  logic                       mem_rsp_err_i,
   output logic                       resp_valid_o,
   input  logic                       resp_ready_i,
   output logic [VPN1_WD+VPN0_WD-1:0] resp_vpn_o,
   output logic [ASID_WD-1:0]         resp_asid_o,
   output logic [31:0]                resp_pte_o,
   output logic                       resp_level_o,
   output logic                       resp_fault_o
);

   // state     | meaning
   // S_IDLE    | ready for a miss, latches vpn/asid/satp on accept
   // S_L1_REQ  | issuing root-level PTE read
   // S_L1_WAIT | waiting for root-level PTE
   // S_L0_REQ  | issuing leaf-level PTE read
   // S_L0_WAIT | waiting for leaf-level PTE
   // S_RESP    | result held until the TLB takes it
   typedef enum logic [2:0] {
      S_IDLE, S_L1_REQ, S_L1_WAIT, S_L0_REQ, S_L0_WAIT, S_RESP
   } state_t;

   localparam int VPN_WD = VPN1_WD + VPN0_WD;

   state_t                 state_q, state_d;
   logic [VPN_WD-1:0]      vpn_q;
   logic [ASID_WD-1:0]     asid_q;
   logic [PPN_WD-1:0]      satp_q;
   logic [PPN_WD-1:0]      ptr_q;
   logic [31:0]            resp_pte_q;
   logic                   resp_level_q;
   logic                   resp_fault_q;

   logic                   accept;
   logic                   cache_hit;
   logic [PPN_WD-1:0]      cache_ppn;
   logic                   pte_v, pte_r, pte_w, pte_x;
   logic                   pte_bad, pte_leaf, sp_misalign;
   logic                   l1_fault, l0_fault;
   logic                   l1_done, l0_done, l1_ptr;
   logic [PPN_WD-1:0]      pte_ppn;
   logic [PHY_ADDR-1:0]    l1_addr, l0_addr;

   assign accept   = req_valid_i && (state_q == S_IDLE);
   assign pte_v    = mem_rsp_data_i[0];
   assign pte_r    = mem_rsp_data_i[1];
   assign pte_w    = mem_rsp_data_i[2];
   assign pte_x    = mem_rsp_data_i[3];
   assign pte_ppn  = mem_rsp_data_i[31:10];

   assign pte_bad     = mem_rsp_err_i || !pte_v || (!pte_r && pte_w);
   assign pte_leaf    = pte_r || pte_x;
   // A superpage leaf must have its low PPN bits clear to be 4 MiB aligned.
   assign sp_misalign = |mem_rsp_data_i[10 +: VPN0_WD];
   assign l1_fault    = pte_bad || (pte_leaf && sp_misalign);
   assign l0_fault    = pte_bad || !pte_leaf;

   assign l1_done = (state_q == S_L1_WAIT) && mem_rsp_valid_i;
   assign l0_done = (state_q == S_L0_WAIT) && mem_rsp_valid_i;
   assign l1_ptr  = l1_done && !pte_bad && !pte_leaf;

   assign l1_addr = PHY_ADDR'({satp_q, vpn_q[VPN_WD-1 -: VPN1_WD], 2'b00});
   assign l0_addr = PHY_ADDR'({ptr_q, vpn_q[VPN0_WD-1:0], 2'b00});

`ifdef SV32_PTW_PTE_CACHE_EN
   logic                        cache_vld_q;
   logic [PPN_WD+VPN1_WD-1:0]   cache_tag_q;
   logic [PPN_WD-1:0]           cache_ppn_q;
   logic                        flush_seen_q;

   assign cache_hit = cache_vld_q && !flush_i &&
                      (cache_tag_q == {satp_ppn_i, req_vpn_i[VPN_WD-1 -: VPN1_WD]});
   assign cache_ppn = cache_ppn_q;

   // A flush seen anywhere in a walk keeps that walk's pointer out of the cache.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cache_vld_q  <= 1'b0;
         cache_tag_q  <= '0;
         cache_ppn_q  <= '0;
         flush_seen_q <= 1'b0;
      end else begin
         if (accept) flush_seen_q <= flush_i;
         else if (flush_i) flush_seen_q <= 1'b1;

         if (flush_i) begin
            cache_vld_q <= 1'b0;
         end else if (l1_ptr && !flush_seen_q) begin
            cache_vld_q <= 1'b1;
            cache_tag_q <= {satp_q, vpn_q[VPN_WD-1 -: VPN1_WD]};
            cache_ppn_q <= pte_ppn;
         end
      end
   end
`else
   logic flush_unused;

   assign cache_hit    = 1'b0;
   assign cache_ppn    = '0;
   assign flush_unused = flush_i;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d         = state_q;
      mem_req_valid_o = 1'b0;
      mem_req_addr_o  = '0;
      case (state_q)
         S_IDLE: begin
            if (req_valid_i) state_d = cache_hit ? S_L0_REQ : S_L1_REQ;
         end
         S_L1_REQ: begin
            mem_req_valid_o = 1'b1;
            mem_req_addr_o  = l1_addr;
            if (mem_req_ready_i) state_d = S_L1_WAIT;
         end
         S_L1_WAIT: begin
            if (mem_rsp_valid_i) state_d = (l1_fault || pte_leaf) ? S_RESP : S_L0_REQ;
         end
         S_L0_REQ: begin
            mem_req_valid_o = 1'b1;
            mem_req_addr_o  = l0_addr;
            if (mem_req_ready_i) state_d = S_L0_WAIT;
         end
         S_L0_WAIT: begin
            if (mem_rsp_valid_i) state_d = S_RESP;
         end
         S_RESP: begin
            if (resp_ready_i) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vpn_q        <= '0;
         asid_q       <= '0;
         satp_q       <= '0;
         ptr_q        <= '0;
         resp_pte_q   <= '0;
         resp_level_q <= 1'b0;
         resp_fault_q <= 1'b0;
      end else begin
         if (accept) begin
            vpn_q  <= req_vpn_i;
            asid_q <= req_asid_i;
            satp_q <= satp_ppn_i;
            if (cache_hit) ptr_q <= cache_ppn;
         end
         if (l1_done) begin
            ptr_q <= pte_ppn;
            if (l1_fault || pte_leaf) begin
               resp_pte_q   <= l1_fault ? 32'h0 : mem_rsp_data_i;
               resp_level_q <= 1'b1;
               resp_fault_q <= l1_fault;
            end
         end
         if (l0_done) begin
            resp_pte_q   <= l0_fault ? 32'h0 : mem_rsp_data_i;
            resp_level_q <= 1'b0;
            resp_fault_q <= l0_fault;
         end
      end
   end

   assign req_ready_o  = (state_q == S_IDLE);
   assign resp_valid_o = (state_q == S_RESP);
   assign resp_vpn_o   = vpn_q;
   assign resp_asid_o  = asid_q;
   assign resp_pte_o   = resp_pte_q;
   assign resp_level_o = resp_level_q;
   assign resp_fault_o = resp_fault_q;

endmodule

// File: tb/tb_sv32_page_walker.sv
// Directed bench for sv32_page_walker with a zero-wait PTE memory model.
// Works with or without SV32_PTW_PTE_CACHE_EN defined.
module tb_sv32_page_walker;

`ifdef SV32_PTW_PTE_CACHE_EN
   localparam bit CACHE = 1'b1;
`else
   localparam bit CACHE = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid_i, req_ready_o;
   logic [19:0] req_vpn_i;
   logic [8:0]  req_asid_i;
   logic [21:0] satp_ppn_i;
   logic        flush_i;
   logic        mem_req_valid_o, mem_req_ready_i;
   logic [33:0] mem_req_addr_o;
   logic        mem_rsp_valid_i;
   logic [31:0] mem_rsp_data_i;
   logic        mem_rsp_err_i;
   logic        resp_valid_o, resp_ready_i;
   logic [19:0] resp_vpn_o;
   logic [8:0]  resp_asid_o;
   logic [31:0] resp_pte_o;
   logic        resp_level_o, resp_fault_o;

   always #5 clk = ~clk;

   sv32_page_walker dut (
      .clk(clk), .rst(rst),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_vpn_i(req_vpn_i), .req_asid_i(req_asid_i),
      .satp_ppn_i(satp_ppn_i), .flush_i(flush_i),
      .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
      .mem_req_addr_o(mem_req_addr_o),
      .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_data_i(mem_rsp_data_i),
      .mem_rsp_err_i(mem_rsp_err_i),
      .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
      .resp_vpn_o(resp_vpn_o), .resp_asid_o(resp_asid_o),
      .resp_pte_o(resp_pte_o), .resp_level_o(resp_level_o),
      .resp_fault_o(resp_fault_o)
   );

   int total = 0;
   int bad   = 0;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // memory model state
   logic [31:0] mem_d [logic [33:0]];
   bit          mem_e [logic [33:0]];
   bit          pend;
   logic [33:0] pend_addr;
   int          reads;
   int          stall_left;
   bit          stall_seen;
   bit          addr_moved;
   logic [33:0] stall_addr;
   logic [33:0] addr_q [$];

   task automatic mem_step();
      if (pend) begin
         mem_rsp_valid_i = 1'b1;
         mem_rsp_data_i  = mem_d.exists(pend_addr) ? mem_d[pend_addr] : 32'h0;
         mem_rsp_err_i   = mem_e.exists(pend_addr) ? mem_e[pend_addr] : 1'b0;
         pend = 1'b0;
      end else begin
         mem_rsp_valid_i = 1'b0;
         mem_rsp_data_i  = 32'h0;
         mem_rsp_err_i   = 1'b0;
      end
      mem_req_ready_i = 1'b0;
      if (mem_req_valid_o) begin
         if (stall_left > 0) begin
            if (!stall_seen) begin
               stall_seen = 1'b1;
               stall_addr = mem_req_addr_o;
            end else if (mem_req_addr_o != stall_addr) addr_moved = 1'b1;
            stall_left--;
         end else begin
            if (stall_seen && mem_req_addr_o != stall_addr) addr_moved = 1'b1;
            stall_seen      = 1'b0;
            mem_req_ready_i = 1'b1;
            pend            = 1'b1;
            pend_addr       = mem_req_addr_o;
            addr_q.push_back(mem_req_addr_o);
            reads++;
         end
      end
   endtask

   task automatic step();
      @(negedge clk);
      mem_step();
   endtask

   task automatic flush_pulse();
      flush_i = 1'b1;
      step();
      flush_i = 1'b0;
   endtask

   task automatic walk(input string tag, input logic [19:0] vpn, input logic [21:0] satp,
                       input logic [33:0] exp_a0, input int exp_lat, input int exp_reads,
                       input logic [31:0] exp_pte, input logic exp_lvl, input logic exp_flt,
                       input int mem_stall, input int resp_stall, input bit flush_mid);
      int          lat;
      bit          rdy_seen;
      logic [63:0] held;
      reads = 0;
      addr_q.delete();
      stall_left = mem_stall;
      stall_seen = 1'b0;
      addr_moved = 1'b0;
      check_val({tag, " idle_ready"}, 64'(req_ready_o), 64'd1);
      req_valid_i = 1'b1;
      req_vpn_i   = vpn;
      req_asid_i  = vpn[8:0];
      satp_ppn_i  = satp;
      step();
      req_valid_i = 1'b0;
      satp_ppn_i  = 22'h3FFFFF;
      lat      = 1;
      rdy_seen = 1'b0;
      while (!resp_valid_o && lat < 40) begin
         if (req_ready_o) rdy_seen = 1'b1;
         if (flush_mid && lat == 2) flush_i = 1'b1;
         step();
         flush_i = 1'b0;
         lat++;
      end
      check_val({tag, " latency"}, 64'(lat), 64'(exp_lat));
      check_val({tag, " busy_ready"}, 64'(rdy_seen), 64'd0);
      held = {resp_valid_o, resp_fault_o, resp_level_o, resp_asid_o, resp_vpn_o};
      repeat (resp_stall) step();
      check_val({tag, " resp_hold"},
                {resp_valid_o, resp_fault_o, resp_level_o, resp_asid_o, resp_vpn_o}, held);
      check_val({tag, " pte"}, 64'(resp_pte_o), 64'(exp_pte));
      check_val({tag, " level"}, 64'(resp_level_o), 64'(exp_lvl));
      check_val({tag, " fault"}, 64'(resp_fault_o), 64'(exp_flt));
      check_val({tag, " vpn_asid"}, {resp_vpn_o, resp_asid_o}, {vpn, vpn[8:0]});
      check_val({tag, " reads"}, 64'(reads), 64'(exp_reads));
      check_val({tag, " addr0"}, 64'((addr_q.size() > 0) ? addr_q[0] : 34'h3FFFFFFFF), 64'(exp_a0));
      check_val({tag, " addr_stable"}, 64'(addr_moved), 64'd0);
      resp_ready_i = 1'b1;
      step();
      resp_ready_i = 1'b0;
      check_val({tag, " back_idle"}, {resp_valid_o, req_ready_o}, 64'b01);
   endtask

   // {satp=0x123, vpn1=0x101} root slot; pointer PPN 0x2AF0 puts the leaf table at 0x2AF0000
   task automatic load_4k();
      mem_d.delete();
      mem_e.delete();
      mem_d[34'h123404]  = 32'h00ABC001;
      mem_d[34'h2AF0014] = 32'h1234500F;
      mem_d[34'h2AF0018] = 32'h5555500F;
   endtask

   initial begin
      rst = 1'b0;
      req_valid_i = 0; req_vpn_i = 0; req_asid_i = 0; satp_ppn_i = 0; flush_i = 0;
      mem_req_ready_i = 0; mem_rsp_valid_i = 0; mem_rsp_data_i = 0; mem_rsp_err_i = 0;
      resp_ready_i = 0;
      pend = 0; reads = 0; stall_left = 0; stall_seen = 0; addr_moved = 0; stall_addr = 0;
      pend_addr = 0;
      repeat (3) @(negedge clk);
      check_val("reset_outputs",
                {req_ready_o, mem_req_valid_o, mem_req_addr_o, resp_valid_o, resp_level_o, resp_fault_o},
                {1'b1, 1'b0, 34'h0, 1'b0, 1'b0, 1'b0});
      check_val("reset_resp_data", {resp_pte_o, resp_vpn_o, resp_asid_o}, 64'h0);
      rst = 1'b1;
      step();

      load_4k();
      walk("walk_4k", 20'h40405, 22'h123, 34'h123404, 5, 2, 32'h1234500F, 1'b0, 1'b0, 0, 0, 1'b0);

      mem_d.delete(); mem_e.delete();
      mem_d[34'h20000C] = 32'h20000007;
      walk("superpage", 20'h00C01, 22'h200, 34'h20000C, 3, 1, 32'h20000007, 1'b1, 1'b0, 0, 0, 1'b0);
      mem_d[34'h20000C] = 32'h20000407;
      walk("sp_misalign", 20'h00C01, 22'h200, 34'h20000C, 3, 1, 32'h0, 1'b1, 1'b1, 0, 0, 1'b0);
      mem_d[34'h20000C] = 32'h00000004;
      walk("w_no_r", 20'h00C01, 22'h200, 34'h20000C, 3, 1, 32'h0, 1'b1, 1'b1, 0, 0, 1'b0);
      mem_d[34'h20000C] = 32'h20000007;
      mem_e[34'h20000C] = 1'b1;
      walk("bus_err", 20'h00C01, 22'h200, 34'h20000C, 3, 1, 32'h0, 1'b1, 1'b1, 0, 0, 1'b0);

      mem_d.delete(); mem_e.delete();
      mem_d[34'h300000] = 32'h00000C01;
      mem_d[34'h3008]   = 32'h00000001;
      walk("l0_pointer", 20'h00002, 22'h300, 34'h300000, 5, 2, 32'h0, 1'b0, 1'b1, 0, 0, 1'b0);

      load_4k();
      flush_pulse();
      walk("backpressure", 20'h40405, 22'h123, 34'h123404, 10, 2, 32'h1234500F, 1'b0, 1'b0, 5, 4, 1'b0);

      mem_rsp_valid_i = 1'b1;
      mem_rsp_data_i  = 32'h1234500F;
      step();
      check_val("stray_rsp", {resp_valid_o, req_ready_o, mem_req_valid_o}, 64'b010);

      flush_pulse();
      walk("flush_mid", 20'h40405, 22'h123, 34'h123404, 5, 2, 32'h1234500F, 1'b0, 1'b0, 0, 0, 1'b1);
      walk("no_fill_after_flush", 20'h40405, 22'h123, 34'h123404, 5, 2, 32'h1234500F, 1'b0, 1'b0, 0, 0, 1'b0);
      walk("same_vpn1", 20'h40406, 22'h123, CACHE ? 34'h2AF0018 : 34'h123404,
           CACHE ? 3 : 5, CACHE ? 1 : 2, 32'h5555500F, 1'b0, 1'b0, 0, 0, 1'b0);
      flush_pulse();
      walk("after_flush", 20'h40405, 22'h123, 34'h123404, 5, 2, 32'h1234500F, 1'b0, 1'b0, 0, 0, 1'b0);

      // reset while the leaf read is outstanding
      flush_pulse();
      req_valid_i = 1'b1;
      req_vpn_i   = 20'h40405;
      req_asid_i  = 9'h005;
      satp_ppn_i  = 22'h123;
      step();
      req_valid_i = 1'b0;
      repeat (3) step();
      rst = 1'b0;
      #1;
      check_val("rst_mid_ctrl",
                {req_ready_o, mem_req_valid_o, mem_req_addr_o, resp_valid_o, resp_level_o, resp_fault_o},
                {1'b1, 1'b0, 34'h0, 1'b0, 1'b0, 1'b0});
      check_val("rst_mid_data", {resp_pte_o, resp_vpn_o, resp_asid_o}, 64'h0);
      pend = 1'b0;
      mem_rsp_valid_i = 1'b0;
      step();
      rst = 1'b1;
      step();
      walk("after_reset", 20'h40405, 22'h123, 34'h123404, 5, 2, 32'h1234500F, 1'b0, 1'b0, 0, 0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
